// File: rtl/dfe_pkg.sv
// Shared types and PAM4 helpers for the adaptive decision-feedback equalizer.
// Symbol index 0..3 maps to levels -3,-1,+1,+3 times half the level spacing.
package dfe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_TRACK = 2'd2
    } dfe_state_t;

    typedef logic [1:0] symbol_t;

    function automatic int sym_level(input symbol_t s, input int sep);
        return ((2 * int'(s)) - 3) * sep / 2;
    endfunction

    // Decision thresholds sit at -sep, 0 and +sep.
    function automatic symbol_t slice_level(input int eq, input int sep);
        if (eq >= sep)
            return 2'd3;
        else if (eq >= 0)
            return 2'd2;
        else if (eq >= -sep)
            return 2'd1;
        else
            return 2'd0;
    endfunction

endpackage

// File: rtl/pam4_slicer.sv
// Combinational PAM4 slicer: decides the nearest symbol and reports its ideal level.
module pam4_slicer
    import dfe_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int SEP   = 56,
    parameter int LVL_W = 8
)(
    input  logic signed [IN_W-1:0]  eq,
    output symbol_t                 symbol,
    output logic signed [LVL_W-1:0] level
);

    always_comb begin
        symbol = slice_level(int'(eq), SEP);
        level  = LVL_W'(sym_level(symbol, SEP));
    end

endmodule

// File: rtl/dfe_pam4_adaptive.sv
// PAM4 decision-feedback equalizer with sign-sign LMS tap adaptation,
// a training/tracking sequencer and a direct coefficient write port.
module dfe_pam4_adaptive
    import dfe_pkg::*;
#(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int NUM_TAPS          = 4,
    parameter int SYMBOL_SEPARATION = 56,
    parameter int COEF_WIDTH        = 8,
    parameter int COEF_FRAC         = 6,
    parameter int MU_STEP           = 1,
    parameter int TRAIN_LEN         = 16,
    localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
)(
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [SIGNAL_RESOLUTION-1:0] signal_in,
    input  logic                                signal_in_valid,
    input  logic [1:0]                          train_data,
    input  logic                                train_data_valid,
    input  logic                                train_start,
    input  logic                                adapt_freeze,
    input  logic                                coef_wr_en,
    input  logic [IDX_W-1:0]                    coef_wr_idx,
    input  logic signed [COEF_WIDTH-1:0]        coef_wr_data,
    output logic signed [SIGNAL_RESOLUTION-1:0] signal_out,
    output logic [1:0]                          symbol_out,
    output logic                                signal_out_valid,
    output logic [NUM_TAPS*COEF_WIDTH-1:0]      taps_out,
    output logic [1:0]                          state_out
);

    localparam int LVL_MAX = (3 * SYMBOL_SEPARATION) / 2;
    localparam int LVL_W   = $clog2(LVL_MAX + 1) + 1;
    localparam int FB_W    = COEF_WIDTH + LVL_W + $clog2(NUM_TAPS + 1);
    localparam int EQ_W    = ((FB_W > SIGNAL_RESOLUTION) ? FB_W : SIGNAL_RESOLUTION) + 1;
    localparam int ERR_W   = ((LVL_W > SIGNAL_RESOLUTION) ? LVL_W : SIGNAL_RESOLUTION) + 1;
    localparam int CW2     = COEF_WIDTH + $clog2(MU_STEP + 1) + 1;
    localparam int CNT_W   = $clog2(TRAIN_LEN + 1);

    localparam logic signed [EQ_W-1:0] EQ_MAX = EQ_W'(2**(SIGNAL_RESOLUTION-1) - 1);
    localparam logic signed [EQ_W-1:0] EQ_MIN = -EQ_MAX - 1;
    localparam logic signed [CW2-1:0]  C_MAX  = CW2'(2**(COEF_WIDTH-1) - 1);
    localparam logic signed [CW2-1:0]  C_MIN  = -C_MAX - 1;

    dfe_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic signed [COEF_WIDTH-1:0] coef     [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0] coef_nxt [NUM_TAPS];
    symbol_t                      hist     [NUM_TAPS];
    logic signed [LVL_W-1:0]      hist_lvl [NUM_TAPS];

    logic signed [FB_W-1:0]              fb_sum;
    logic signed [EQ_W-1:0]              eq_raw;
    logic signed [SIGNAL_RESOLUTION-1:0] eq;
    symbol_t                             dec_sym;
    logic signed [LVL_W-1:0]             dec_lvl;
    logic signed [LVL_W-1:0]             tr_lvl;
    symbol_t                             tr_sym_unused;
    logic signed [LVL_W-1:0]             tr_ref_lvl;
    logic signed [LVL_W-1:0]             ref_lvl;
    logic signed [ERR_W-1:0]             err;
    logic                                adapt_en;

    always_comb begin
        fb_sum = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            hist_lvl[k] = LVL_W'(sym_level(hist[k], SYMBOL_SEPARATION));
            fb_sum = fb_sum + (FB_W'(coef[k]) * FB_W'(hist_lvl[k]));
        end
        eq_raw = EQ_W'(signal_in) - EQ_W'(fb_sum >>> COEF_FRAC);
        if (eq_raw > EQ_MAX)
            eq = EQ_MAX[SIGNAL_RESOLUTION-1:0];
        else if (eq_raw < EQ_MIN)
            eq = EQ_MIN[SIGNAL_RESOLUTION-1:0];
        else
            eq = eq_raw[SIGNAL_RESOLUTION-1:0];
    end

    pam4_slicer #(
        .IN_W  (SIGNAL_RESOLUTION),
        .SEP   (SYMBOL_SEPARATION),
        .LVL_W (LVL_W)
    ) u_dec_slicer (
        .eq     (eq),
        .symbol (dec_sym),
        .level  (dec_lvl)
    );

    // The training symbol is presented at its ideal level, so slicing it
    // returns the same symbol and the reference level for the error term.
    assign tr_lvl = LVL_W'(sym_level(train_data, SYMBOL_SEPARATION));

    pam4_slicer #(
        .IN_W  (LVL_W),
        .SEP   (SYMBOL_SEPARATION),
        .LVL_W (LVL_W)
    ) u_ref_slicer (
        .eq     (tr_lvl),
        .symbol (tr_sym_unused),
        .level  (tr_ref_lvl)
    );

    assign adapt_en = !adapt_freeze && signal_in_valid &&
                      (((state == ST_TRAIN) && train_data_valid) || (state == ST_TRACK));
    assign ref_lvl  = (state == ST_TRAIN) ? tr_ref_lvl : dec_lvl;
    assign err      = ERR_W'(eq) - ERR_W'(ref_lvl);

    // Sign-sign LMS: step toward agreement of error sign and history level sign.
    always_comb begin
        logic signed [CW2-1:0] c_ext;
        logic                  lvl_pos;
        for (int k = 0; k < NUM_TAPS; k++) begin
            c_ext   = CW2'(coef[k]);
            lvl_pos = hist[k][1];
            if (adapt_en && (err != '0)) begin
                if (err[ERR_W-1] != lvl_pos)
                    c_ext = c_ext + CW2'(MU_STEP);
                else
                    c_ext = c_ext - CW2'(MU_STEP);
            end
            if (c_ext > C_MAX)
                coef_nxt[k] = C_MAX[COEF_WIDTH-1:0];
            else if (c_ext < C_MIN)
                coef_nxt[k] = C_MIN[COEF_WIDTH-1:0];
            else
                coef_nxt[k] = c_ext[COEF_WIDTH-1:0];
            if (coef_wr_en && (coef_wr_idx == IDX_W'(k)))
                coef_nxt[k] = coef_wr_data;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (train_start) begin
            state_nxt = ST_TRAIN;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_TRAIN: begin
                    if (signal_in_valid && train_data_valid) begin
                        if (cnt == CNT_W'(TRAIN_LEN - 1)) begin
                            state_nxt = ST_TRACK;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            signal_out       <= '0;
            symbol_out       <= '0;
            signal_out_valid <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                coef[k] <= '0;
                hist[k] <= 2'd2;
            end
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            signal_out_valid <= signal_in_valid;
            for (int k = 0; k < NUM_TAPS; k++)
                coef[k] <= coef_nxt[k];
            if (signal_in_valid) begin
                signal_out <= eq;
                symbol_out <= dec_sym;
                for (int k = NUM_TAPS - 1; k > 0; k--)
                    hist[k] <= hist[k-1];
                hist[0] <= dec_sym;
            end
        end
    end

    always_comb begin
        taps_out = '0;
        for (int k = 0; k < NUM_TAPS; k++)
            taps_out[k*COEF_WIDTH +: COEF_WIDTH] = coef[k];
    end

    assign state_out = state;

endmodule

// File: tb/tb_dfe_pam4_adaptive.sv
// Randomized self-checking bench for dfe_pam4_adaptive against an integer
// behavioural model of the equalizer, slicer, LMS update and sequencer.
module tb_dfe_pam4_adaptive;

    localparam int NT  = 4;
    localparam int CW  = 8;
    localparam int CF  = 6;
    localparam int SEP = 56;
    localparam int MU  = 1;
    localparam int TL  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [7:0] signal_in;
    logic              signal_in_valid;
    logic [1:0]        train_data;
    logic              train_data_valid;
    logic              train_start;
    logic              adapt_freeze;
    logic              coef_wr_en;
    logic [1:0]        coef_wr_idx;
    logic signed [7:0] coef_wr_data;
    logic signed [7:0] signal_out;
    logic [1:0]        symbol_out;
    logic              signal_out_valid;
    logic [31:0]       taps_out;
    logic [1:0]        state_out;

    dfe_pam4_adaptive dut (
        .clk              (clk),
        .rst              (rst),
        .signal_in        (signal_in),
        .signal_in_valid  (signal_in_valid),
        .train_data       (train_data),
        .train_data_valid (train_data_valid),
        .train_start      (train_start),
        .adapt_freeze     (adapt_freeze),
        .coef_wr_en       (coef_wr_en),
        .coef_wr_idx      (coef_wr_idx),
        .coef_wr_data     (coef_wr_data),
        .signal_out       (signal_out),
        .symbol_out       (symbol_out),
        .signal_out_valid (signal_out_valid),
        .taps_out         (taps_out),
        .state_out        (state_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int mh [NT];
    int mhist [NT];
    int mst, mcnt, mso, msym, mval;

    function automatic int lv(input int s);
        return (2 * s - 3) * SEP / 2;
    endfunction

    function automatic int sgn(input int x);
        return (x > 0) ? 1 : ((x < 0) ? -1 : 0);
    endfunction

    function automatic int clamp(input int x, input int lo, input int hi);
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int fb, eq, sym, ref_s, e;
        int nh [NT];
        bit ad;
        if (rst) begin
            for (int k = 0; k < NT; k++) begin
                mh[k]    = 0;
                mhist[k] = 2;
            end
            mst = 0; mcnt = 0; mso = 0; msym = 0; mval = 0;
            return;
        end
        fb = 0;
        for (int k = 0; k < NT; k++)
            fb += mh[k] * lv(mhist[k]);
        fb  = fb >>> CF;
        eq  = clamp(int'(signal_in) - fb, -128, 127);
        sym = (eq >= SEP) ? 3 : (eq >= 0) ? 2 : (eq >= -SEP) ? 1 : 0;
        ad = 0;
        ref_s = sym;
        if (!adapt_freeze && signal_in_valid) begin
            if (mst == 1 && train_data_valid) begin
                ad = 1;
                ref_s = int'(train_data);
            end else if (mst == 2) begin
                ad = 1;
            end
        end
        e = eq - lv(ref_s);
        for (int k = 0; k < NT; k++) begin
            nh[k] = mh[k];
            if (ad)
                nh[k] = clamp(mh[k] + MU * sgn(e) * sgn(lv(mhist[k])), -128, 127);
        end
        if (coef_wr_en && int'(coef_wr_idx) < NT)
            nh[int'(coef_wr_idx)] = int'(coef_wr_data);
        mh = nh;
        if (signal_in_valid) begin
            for (int k = NT - 1; k > 0; k--)
                mhist[k] = mhist[k-1];
            mhist[0] = sym;
            mso  = eq;
            msym = sym;
        end
        mval = int'(signal_in_valid);
        if (train_start) begin
            mst = 1; mcnt = 0;
        end else if (mst == 1 && signal_in_valid && train_data_valid) begin
            mcnt++;
            if (mcnt == TL) begin
                mst = 2; mcnt = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] exp_taps;
        for (int k = 0; k < NT; k++)
            exp_taps[k*CW +: CW] = 8'(mh[k]);
        chk("signal_out", int'(signal_out), mso);
        chk("symbol_out", int'(symbol_out), msym);
        chk("signal_out_valid", int'(signal_out_valid), mval);
        chk("taps_out", longint'(taps_out), longint'(exp_taps));
        chk("state_out", int'(state_out), mst);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic quiet();
        signal_in_valid  = 1'b0;
        train_data_valid = 1'b0;
        train_start      = 1'b0;
        adapt_freeze     = 1'b0;
        coef_wr_en       = 1'b0;
        coef_wr_idx      = 2'd0;
        coef_wr_data     = 8'sd0;
        train_data       = 2'd0;
        signal_in        = 8'sd0;
    endtask

    initial begin
        logic [31:0] prev_taps;
        int counted;
        int d;
        rst = 1'b1;
        quiet();
        tick();
        tick();
        chk("reset_signal_out", int'(signal_out), 0);
        chk("reset_symbol_out", int'(symbol_out), 0);
        chk("reset_valid", int'(signal_out_valid), 0);
        chk("reset_taps", longint'(taps_out), 0);
        chk("reset_state", int'(state_out), 0);

        rst = 1'b0;
        signal_in = 8'sd30; signal_in_valid = 1'b1;
        tick();
        chk("pass_signal", int'(signal_out), 30);
        chk("pass_symbol", int'(symbol_out), 2);
        chk("pass_valid", int'(signal_out_valid), 1);

        quiet();
        coef_wr_en = 1'b1; coef_wr_idx = 2'd0; coef_wr_data = 8'sd32;
        tick();
        chk("write_h0", longint'(taps_out), 32'h0000_0020);
        quiet();
        // Prior decision +28 gives feedback 14: 100-14=86 decides symbol 3.
        signal_in = 8'sd100; signal_in_valid = 1'b1;
        tick();
        chk("prime3_signal", int'(signal_out), 86);
        chk("prime3_symbol", int'(symbol_out), 3);
        signal_in = 8'sd70;
        tick();
        chk("feedback_signal", int'(signal_out), 28);
        chk("feedback_symbol", int'(symbol_out), 2);
        signal_in = -8'sd128;
        tick();
        chk("neg_sat_signal", int'(signal_out), -128);
        chk("neg_sat_symbol", int'(symbol_out), 0);
        signal_in = 8'sd100;
        tick();
        chk("pos_sat_signal", int'(signal_out), 127);
        chk("pos_sat_symbol", int'(symbol_out), 3);

        for (int i = 0; i < 20; i++) begin
            signal_in = 8'($urandom);
            signal_in_valid = 1'($urandom);
            tick();
        end
        chk("idle_no_adapt", longint'(taps_out), 32'h0000_0020);

        quiet();
        train_start = 1'b1;
        tick();
        train_start = 1'b0;
        chk("train_entered", int'(state_out), 1);
        counted = 0;
        for (int i = 0; i < TL + 1; i++) begin
            signal_in_valid  = 1'b1;
            train_data_valid = (i != 5);
            train_data       = 2'($urandom);
            signal_in        = 8'(lv(int'(train_data)) + int'($urandom_range(0, 40)) - 20);
            prev_taps        = taps_out;
            tick();
            if (train_data_valid) counted++;
            for (int k = 0; k < NT; k++) begin
                d = int'($signed(taps_out[k*CW +: CW])) - int'($signed(prev_taps[k*CW +: CW]));
                chk("train_step_bound", (d > MU || d < -MU) ? 1 : 0, 0);
            end
            if (counted == TL - 1 && train_data_valid)
                chk("still_training", int'(state_out), 1);
        end
        chk("track_after_train", int'(state_out), 2);

        quiet();
        signal_in = 8'sd45; signal_in_valid = 1'b1;
        coef_wr_en = 1'b1; coef_wr_idx = 2'd0; coef_wr_data = 8'sd10;
        tick();
        chk("collision_h0", int'($signed(taps_out[7:0])), 10);

        quiet();
        prev_taps = taps_out;
        adapt_freeze = 1'b1;
        for (int i = 0; i < 8; i++) begin
            signal_in = 8'($urandom);
            signal_in_valid = 1'b1;
            tick();
        end
        chk("freeze_hold", longint'(taps_out), longint'(prev_taps));

        quiet();
        train_start = 1'b1;
        tick();
        train_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            signal_in = 8'($urandom); signal_in_valid = 1'b1;
            train_data = 2'($urandom); train_data_valid = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midtrain_reset_state", int'(state_out), 0);
        chk("midtrain_reset_taps", longint'(taps_out), 0);

        for (int i = 0; i < 3000; i++) begin
            rst              = ($urandom_range(0, 499) == 0);
            train_start      = ($urandom_range(0, 39) == 0);
            signal_in_valid  = ($urandom_range(0, 3) != 0);
            train_data_valid = ($urandom_range(0, 3) != 0);
            adapt_freeze     = ($urandom_range(0, 7) == 0);
            coef_wr_en       = ($urandom_range(0, 19) == 0);
            coef_wr_idx      = 2'($urandom);
            coef_wr_data     = 8'($urandom);
            train_data       = 2'($urandom);
            signal_in        = 8'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
